// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
//   - FSM state encoding (IDLE / ISSUE / WAIT_RD)
//   - master identifiers (CPU load/store path, auxiliary requester)
//   - default bus widths
package mem_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE    = 2'd0;
   localparam arb_state_t ST_ISSUE   = 2'd1;
   localparam arb_state_t ST_WAIT_RD = 2'd2;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// Ports:
//   req_i[1:0]  request vector (bit n = master n)
//   last_i      master that owned the most recent transfer
//   valid_o     at least one request present
//   winner_o    chosen master; under contention the non-owner wins
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       valid_o,
   output logic       winner_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = M_CPU;
      if (req_i == 2'b11) begin
         winner_o = ~last_i;
      end else if (req_i[1]) begin
         winner_o = M_AUX;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises single-word transfers from two masters onto one
// single-port memory bus with round-robin fairness.
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   mN_req/we/addr/wdata    master N command (N = 0 CPU, 1 auxiliary)
//   mN_gnt                  one-cycle pulse: master N command accepted
//   mN_rvalid/rdata         one-cycle pulse with master N read data
//   mem_addr/data/we        memory strobes, mem_q memory read data
//   owner                   master of the current or most recent transfer
//   busy                    high whenever the FSM is not idle
//   dbg_state_o             current FSM state for observation
//
// Handshake: a master raises req with addr/we/wdata stable and holds them
// until it sees gnt; gnt is the acceptance (ready) pulse for that command.
// On the cycle gnt is visible the master either drops req or presents its
// next command. Requests are only sampled while idle, so at most one
// transfer is ever outstanding.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_q,
   output logic              owner,
   output logic              busy,
   output logic [1:0]        dbg_state_o
);

   // WAIT_RD counts RD_LAT-1 down to 0, so RD_LAT of 1..4 fits two bits.
   localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

   arb_state_t        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              pick_valid;
   logic              pick_winner;

   rr_pick2 u_pick (
      .req_i    ({m1_req, m0_req}),
      .last_i   (owner_q),
      .valid_o  (pick_valid),
      .winner_o (pick_winner)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      owner_d    = owner_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_we_d   = 1'b0;
      gnt_d      = 2'b00;
      rvalid_d   = 2'b00;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d    = ST_ISSUE;
               owner_d    = pick_winner;
               gnt_d      = (pick_winner == M_AUX) ? 2'b10 : 2'b01;
               mem_addr_d = (pick_winner == M_AUX) ? m1_addr  : m0_addr;
               mem_data_d = (pick_winner == M_AUX) ? m1_wdata : m0_wdata;
               we_d       = (pick_winner == M_AUX) ? m1_we    : m0_we;
               // The strobe is registered alongside the address so it is
               // high exactly for the ISSUE cycle of a write.
               mem_we_d   = we_d;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_RD;
               cnt_d   = RD_CNT_INIT;
            end
         end
         ST_WAIT_RD: begin
            if (cnt_q == 2'd0) begin
               state_d = ST_IDLE;
               if (owner_q == M_AUX) begin
                  rdata1_d = mem_q;
                  rvalid_d = 2'b10;
               end else begin
                  rdata0_d = mem_q;
                  rvalid_d = 2'b01;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         we_q       <= 1'b0;
         owner_q    <= M_AUX;   // so the CPU wins the first tie
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         gnt_q      <= 2'b00;
         rvalid_q   <= 2'b00;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         owner_q    <= owner_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
         gnt_q      <= gnt_d;
         rvalid_q   <= rvalid_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign m0_gnt      = gnt_q[0];
   assign m1_gnt      = gnt_q[1];
   assign m0_rvalid   = rvalid_q[0];
   assign m1_rvalid   = rvalid_q[1];
   assign m0_rdata    = rdata0_q;
   assign m1_rdata    = rdata1_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data    = mem_data_q;
   assign mem_we      = mem_we_q;
   assign owner       = owner_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (read latency 1 and 3), each with
// its own memory model and a transaction-level reference monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // ---------------- DUT signals, indexed [dut][master] ----------------
   logic          req   [2][2];
   logic          we    [2][2];
   logic [AW-1:0] addr  [2][2];
   logic [DW-1:0] wdata [2][2];
   logic          gnt   [2][2];
   logic          rvalid[2][2];
   logic [DW-1:0] rdata [2][2];
   logic [AW-1:0] mem_addr [2];
   logic [DW-1:0] mem_data [2];
   logic          mem_we   [2];
   logic [DW-1:0] mem_q    [2];
   logic          owner    [2];
   logic          busy     [2];
   logic [1:0]    dbg_state[2];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- DUTs, memories, reference monitors ----------------
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int RDL = (g == 0) ? 1 : 3;

      mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RDL)) u_dut (
         .clock       (clock),
         .reset       (reset),
         .m0_req      (req[g][0]),
         .m0_we       (we[g][0]),
         .m0_addr     (addr[g][0]),
         .m0_wdata    (wdata[g][0]),
         .m0_gnt      (gnt[g][0]),
         .m0_rvalid   (rvalid[g][0]),
         .m0_rdata    (rdata[g][0]),
         .m1_req      (req[g][1]),
         .m1_we       (we[g][1]),
         .m1_addr     (addr[g][1]),
         .m1_wdata    (wdata[g][1]),
         .m1_gnt      (gnt[g][1]),
         .m1_rvalid   (rvalid[g][1]),
         .m1_rdata    (rdata[g][1]),
         .mem_addr    (mem_addr[g]),
         .mem_data    (mem_data[g]),
         .mem_we      (mem_we[g]),
         .mem_q       (mem_q[g]),
         .owner       (owner[g]),
         .busy        (busy[g]),
         .dbg_state_o (dbg_state[g])
      );

      // Memory: write at the end of the strobe cycle, read data appears RDL
      // clocks after the address cycle.
      logic [DW-1:0] mem_arr [256] = '{default: '0};
      logic [DW-1:0] pipe [RDL]    = '{default: '0};
      always @(posedge clock) begin
         if (mem_we[g]) mem_arr[mem_addr[g][7:0]] <= mem_data[g];
         pipe[0] <= mem_arr[mem_addr[g][7:0]];
         for (int k = 1; k < RDL; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_q[g] = pipe[RDL-1];

      // Reference model: grants, strobes and read returns derived from the
      // arbitration and timing rules, with a scoreboard of expected read data.
      logic [DW-1:0] ref_mem [256] = '{default: '0};
      logic [DW-1:0] exp_q [$];
      initial begin : mon
         int            cyc, ok_from, pend_at;
         logic          pend_m, own, any_r, w, ewe, erv0, erv1, eg0, eg1;
         logic [AW-1:0] last_a;
         logic [DW-1:0] last_d;
         logic [DW-1:0] exp_rd [2];
         logic          s_req [2];
         logic          s_we  [2];
         logic [AW-1:0] s_addr[2];
         logic [DW-1:0] s_wd  [2];
         string         p;
         cyc = 0; ok_from = 0; pend_at = -1; pend_m = 1'b0; own = 1'b1;
         last_a = '0; last_d = '0; exp_rd[0] = '0; exp_rd[1] = '0;
         for (int m = 0; m < 2; m++) begin
            s_req[m] = 1'b0; s_we[m] = 1'b0; s_addr[m] = '0; s_wd[m] = '0;
         end
         p = $sformatf("d%0d", g);
         forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
               check_eq({p, "_rst_gnt0"}, gnt[g][0], 0);
               check_eq({p, "_rst_gnt1"}, gnt[g][1], 0);
               check_eq({p, "_rst_rv0"}, rvalid[g][0], 0);
               check_eq({p, "_rst_rv1"}, rvalid[g][1], 0);
               check_eq({p, "_rst_mem_we"}, mem_we[g], 0);
               check_eq({p, "_rst_busy"}, busy[g], 0);
               check_eq({p, "_rst_owner"}, owner[g], 1);
               check_eq({p, "_rst_mem_addr"}, mem_addr[g], 0);
               check_eq({p, "_rst_mem_data"}, mem_data[g], 0);
               check_eq({p, "_rst_rdata0"}, rdata[g][0], 0);
               check_eq({p, "_rst_rdata1"}, rdata[g][1], 0);
               check_eq({p, "_rst_state"}, dbg_state[g], 0);
               own = 1'b1; ok_from = cyc + 2; pend_at = -1; exp_q.delete();
               last_a = '0; last_d = '0; exp_rd[0] = '0; exp_rd[1] = '0;
            end else begin
               any_r = s_req[0] | s_req[1];
               w     = (s_req[0] && s_req[1]) ? ~own : s_req[1];
               eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0;
               if (cyc >= ok_from && any_r) begin
                  eg0 = (w == 1'b0);
                  eg1 = (w == 1'b1);
                  own = w; last_a = s_addr[w]; last_d = s_wd[w]; ewe = s_we[w];
                  if (s_we[w]) begin
                     ref_mem[s_addr[w][7:0]] = s_wd[w];
                     ok_from = cyc + 2;
                  end else begin
                     exp_q.push_back(ref_mem[s_addr[w][7:0]]);
                     pend_at = cyc + RDL + 1;
                     pend_m  = w;
                     ok_from = cyc + RDL + 2;
                  end
               end
               check_eq({p, "_gnt0"}, gnt[g][0], eg0);
               check_eq({p, "_gnt1"}, gnt[g][1], eg1);
               check_eq({p, "_mem_we"}, mem_we[g], ewe);
               check_eq({p, "_mem_addr"}, mem_addr[g], last_a);
               check_eq({p, "_mem_data"}, mem_data[g], last_d);
               check_eq({p, "_owner"}, owner[g], own);
               check_eq({p, "_busy"}, busy[g], (cyc < ok_from - 1));
               erv0 = 1'b0; erv1 = 1'b0;
               if (pend_at == cyc) begin
                  if (pend_m) erv1 = 1'b1; else erv0 = 1'b1;
                  if (exp_q.size() > 0) exp_rd[pend_m] = exp_q.pop_front();
                  pend_at = -1;
               end
               check_eq({p, "_rvalid0"}, rvalid[g][0], erv0);
               check_eq({p, "_rvalid1"}, rvalid[g][1], erv1);
               check_eq({p, "_rdata0"}, rdata[g][0], exp_rd[0]);
               check_eq({p, "_rdata1"}, rdata[g][1], exp_rd[1]);
            end
            for (int m = 0; m < 2; m++) begin
               s_req[m] = req[g][m]; s_we[m] = we[g][m];
               s_addr[m] = addr[g][m]; s_wd[m] = wdata[g][m];
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_cmd(input int d, input int m, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] dt);
      req[d][m] = 1'b1; we[d][m] = w; addr[d][m] = a; wdata[d][m] = dt;
   endtask

   task automatic new_cmd(input int d, input int m);
      set_cmd(d, m, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
              DW'($urandom_range(0, 65535)));
   endtask

   task automatic wait_gnt(input int d, input int m, input string tag, output int lat);
      lat = 0;
      do begin step(); lat++; end while (!gnt[d][m] && lat < 20);
      if (!gnt[d][m]) check_eq({tag, "_gnt_timeout"}, 0, 1);
   endtask

   task automatic wait_rv(input int d, input int m, input string tag, output int lat);
      lat = 0;
      do begin step(); lat++; end while (!rvalid[d][m] && lat < 20);
      if (!rvalid[d][m]) check_eq({tag, "_rvalid_timeout"}, 0, 1);
   endtask

   // Legal random requester: hold until gnt, then drop or present the next.
   task automatic rand_step(input int d, input bit allow);
      for (int m = 0; m < 2; m++) begin
         if (req[d][m] && gnt[d][m]) begin
            if (allow && $urandom_range(0, 1) == 1) new_cmd(d, m);
            else req[d][m] = 1'b0;
         end else if (!req[d][m] && allow && $urandom_range(0, 2) == 0) begin
            new_cmd(d, m);
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int lat, lat2, nwe, ovl, alt_err, last_m, first_m, nrv;
      int cnt [2];
      reset = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int m = 0; m < 2; m++) begin
            req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
         end

      // Reset held with both masters requesting; CPU must win the first tie.
      set_cmd(0, 0, 1'b1, 16'h0001, 16'h1111);
      set_cmd(0, 1, 1'b1, 16'h0002, 16'h2222);
      repeat (3) step();
      check_eq("t1_busy_in_reset", busy[0], 0);
      check_eq("t1_gnt_in_reset", gnt[0][0] | gnt[0][1], 0);
      reset = 1'b1;
      wait_gnt(0, 0, "t1_first", lat);
      check_eq("t1_first_lat", lat, 1);
      check_eq("t1_first_gnt_m1", gnt[0][1], 0);
      check_eq("t1_first_owner", owner[0], 0);
      req[0][0] = 1'b0;
      wait_gnt(0, 1, "t1_second", lat);
      check_eq("t1_second_lat", lat, 2);
      req[0][1] = 1'b0;
      repeat (3) step();

      // CPU write alone.
      set_cmd(0, 0, 1'b1, 16'h0010, 16'hBEEF);
      wait_gnt(0, 0, "t2_wr", lat);
      check_eq("t2_gnt_lat", lat, 1);
      check_eq("t2_mem_we", mem_we[0], 1);
      check_eq("t2_mem_addr", mem_addr[0], 16'h0010);
      check_eq("t2_mem_data", mem_data[0], 16'hBEEF);
      req[0][0] = 1'b0;
      step();
      check_eq("t2_mem_we_off", mem_we[0], 0);
      check_eq("t2_busy_off", busy[0], 0);
      repeat (2) step();

      // Aux read of the just-written word.
      set_cmd(0, 1, 1'b0, 16'h0010, 16'h0000);
      wait_gnt(0, 1, "t3_rd", lat);
      req[0][1] = 1'b0;
      wait_rv(0, 1, "t3_rd", lat);
      check_eq("t3_rv_lat", lat, 2);
      check_eq("t3_rdata", rdata[0][1], 16'hBEEF);
      check_eq("t3_m0_rvalid", rvalid[0][0], 0);
      step();
      check_eq("t3_rv_pulse", rvalid[0][1], 0);
      repeat (2) step();

      // Continuous contention: 6 writes per master, strict alternation.
      nwe = 0; ovl = 0; alt_err = 0; last_m = -1; first_m = -1;
      cnt[0] = 0; cnt[1] = 0;
      set_cmd(0, 0, 1'b1, 16'h0100, 16'hA000);
      set_cmd(0, 1, 1'b1, 16'h0200, 16'hB000);
      for (int i = 0; i < 40; i++) begin
         step();
         if (mem_we[0]) nwe++;
         if (gnt[0][0] && gnt[0][1]) ovl++;
         for (int m = 0; m < 2; m++) begin
            if (gnt[0][m]) begin
               if (first_m < 0) first_m = m;
               if (m == last_m) alt_err++;
               last_m = m;
               cnt[m]++;
               if (cnt[m] < 6)
                  set_cmd(0, m, 1'b1, AW'(16'h0100 * (m + 1) + cnt[m]), DW'(16'hA000 + 16'h1000 * m + cnt[m]));
               else
                  req[0][m] = 1'b0;
            end
         end
      end
      check_eq("t4_first_m0", first_m, 0);
      check_eq("t4_m0_grants", cnt[0], 6);
      check_eq("t4_m1_grants", cnt[1], 6);
      check_eq("t4_alternation", alt_err, 0);
      check_eq("t4_gnt_overlap", ovl, 0);
      check_eq("t4_we_pulses", nwe, 12);

      // CPU keeps req high and presents the next address after its grant.
      set_cmd(0, 0, 1'b1, 16'h0010, 16'h5555);
      wait_gnt(0, 0, "t6_a", lat);
      addr[0][0] = 16'h0011; wdata[0][0] = 16'h6666;
      wait_gnt(0, 0, "t6_b", lat2);
      check_eq("t6_second_gnt_dist", lat2, 2);
      check_eq("t6_mem_addr", mem_addr[0], 16'h0011);
      check_eq("t6_mem_we", mem_we[0], 1);
      req[0][0] = 1'b0;
      repeat (3) step();

      // Reset during WAIT_RD (read latency 3): the read is discarded.
      set_cmd(1, 0, 1'b0, 16'h0030, 16'h0000);
      wait_gnt(1, 0, "t5_rd", lat);
      req[1][0] = 1'b0;
      step(); step();
      check_eq("t5_in_wait_rd", dbg_state[1], 2);
      reset = 1'b0;
      step();
      check_eq("t5_state_idle", dbg_state[1], 0);
      check_eq("t5_busy", busy[1], 0);
      reset = 1'b1;
      nrv = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (rvalid[1][0] || rvalid[1][1]) nrv++;
      end
      check_eq("t5_no_rvalid", nrv, 0);
      set_cmd(1, 0, 1'b1, 16'h0030, 16'h1234);
      wait_gnt(1, 0, "t5_wr", lat);
      check_eq("t5_wr_gnt_lat", lat, 1);
      req[1][0] = 1'b0;
      step();
      set_cmd(1, 0, 1'b0, 16'h0030, 16'h0000);
      wait_gnt(1, 0, "t5_rd2", lat);
      req[1][0] = 1'b0;
      wait_rv(1, 0, "t5_rd2", lat);
      check_eq("t5_rv_lat", lat, 4);
      check_eq("t5_rdata", rdata[1][0], 16'h1234);
      repeat (3) step();

      // Random traffic on both instances, then drain outstanding requests.
      for (int i = 0; i < 600; i++) begin
         step();
         rand_step(0, 1'b1);
         rand_step(1, 1'b1);
      end
      for (int i = 0; i < 40; i++) begin
         step();
         rand_step(0, 1'b0);
         rand_step(1, 1'b0);
      end
      check_eq("drain_d0", req[0][0] | req[0][1], 0);
      check_eq("drain_d1", req[1][0] | req[1][1], 0);
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
